// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction ROM
// and holds each fetched word in a valid/ready output stage toward decode.
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [15:0] fetch_count
);

  logic [7:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  ipc_q, ipc_d;
  logic [15:0] count_q, count_d;
  logic        accept;
  logic        load;

  assign accept = valid_q & instr_ready;
  assign load   = ~valid_q | instr_ready;

  // Redirect wins over load: the presented word is dropped, never counted.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else begin
      if (accept && count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
      if (load) begin
        instr_d = imem_data;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      ipc_q   <= 8'd0;
      count_q <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect,
// PC wrap-around, asynchronous mid-stream reset and counter saturation.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] fetch_count;

  logic [31:0] rom [256];
  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(8'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given inputs, then settle before sampling.
  task automatic applyStimulus(input logic rd, input logic [7:0] rpc, input logic rdy);
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic checkLive(input string tag, input logic [7:0] pc, input logic [31:0] word,
                           input logic [7:0] addr, input logic [15:0] cnt);
    checkOutput({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    checkOutput({tag, ".instr_pc"}, {24'd0, instr_pc}, {24'd0, pc});
    checkOutput({tag, ".instr"}, instr, word);
    checkOutput({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, addr});
    checkOutput({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  task automatic checkBubble(input string tag, input logic [7:0] addr, input logic [15:0] cnt);
    checkOutput({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    checkOutput({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, addr});
    checkOutput({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {24'hC0FFEE, i[7:0]};
    rom[0] = 32'h20010003;
    rom[1] = 32'h20020009;
    rom[2] = 32'h00221020;

    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'd0;
    instr_ready = 1'b0;
    #1;
    checkBubble("reset", 8'd0, 16'd0);
    checkOutput("reset.instr", instr, 32'd0);
    checkOutput("reset.instr_pc", {24'd0, instr_pc}, 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with ready held high.
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("stream0", 8'd0, 32'h20010003, 8'd1, 16'd0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("stream1", 8'd1, 32'h20020009, 8'd2, 16'd1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("stream2", 8'd2, 32'h00221020, 8'd3, 16'd2);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("stream3", 8'd3, 32'hC0FFEE03, 8'd4, 16'd3);

    // Return to address 1, then stall three cycles.
    applyStimulus(1'b1, 8'd1, 1'b1);
    checkBubble("redir1", 8'd1, 16'd3);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("bp_start", 8'd1, 32'h20020009, 8'd2, 16'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkLive("bp_hold", 8'd1, 32'h20020009, 8'd2, 16'd3);
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("bp_release", 8'd2, 32'h00221020, 8'd3, 16'd4);

    // Redirect while the address-1 word is presented with ready high.
    applyStimulus(1'b1, 8'd1, 1'b1);
    checkBubble("redir1b", 8'd1, 16'd4);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("pres1", 8'd1, 32'h20020009, 8'd2, 16'd4);
    applyStimulus(1'b1, 8'd4, 1'b1);
    checkBubble("redir4", 8'd4, 16'd4);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("target4", 8'd4, 32'hC0FFEE04, 8'd5, 16'd4);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("after4", 8'd5, 32'hC0FFEE05, 8'd6, 16'd5);

    // PC wrap-around.
    applyStimulus(1'b1, 8'd254, 1'b1);
    checkBubble("redir254", 8'd254, 16'd5);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("wrap254", 8'd254, 32'hC0FFEEFE, 8'd255, 16'd5);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("wrap255", 8'd255, 32'hC0FFEEFF, 8'd0, 16'd6);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("wrap0", 8'd0, 32'h20010003, 8'd1, 16'd7);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("wrap1", 8'd1, 32'h20020009, 8'd2, 16'd8);

    // Position pc at 7 with a live instruction, then reset between edges.
    applyStimulus(1'b1, 8'd6, 1'b1);
    checkBubble("redir6", 8'd6, 16'd8);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkLive("pc7", 8'd6, 32'hC0FFEE06, 8'd7, 16'd8);
    #2;
    rst = 1'b1;
    #1;
    checkBubble("async_rst", 8'd0, 16'd0);
    checkOutput("async_rst.instr", instr, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("restart0", 8'd0, 32'h20010003, 8'd1, 16'd0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkLive("restart1", 8'd1, 32'h20020009, 8'd2, 16'd1);

    // Saturation: every cycle is an accept from here on.
    repeat (65533) @(posedge clk);
    #1;
    checkOutput("sat_pre", {16'd0, fetch_count}, 32'h0000FFFE);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("sat_reach", {16'd0, fetch_count}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("sat_hold", {16'd0, fetch_count}, 32'h0000FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
